i2c_slave_regs: RTL and testbench

//  I2C target (slave) that answers the controller's START / SLAVE_ID / STOP traffic on the gesture bus.

---
 rtl/i2c_slave_regs.sv | 163 ++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target exposing a byte-addressed register port with pointer auto-increment
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h73,
   parameter int         PTR_W      = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             scl,
   inout  wire              sda,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic [PTR_W-1:0] rd_addr,
   input  logic [7:0]       rd_data,
   output logic             addr_hit,
   output logic             busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RD_LOAD, RDATA, RD_ACK
   } state_t;
   state_t           state, state_n;
   logic [2:0]       scl_p, sda_p;
   logic             rise, fall, start, stop, sda_s;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       sh, sh_n, bt;
   logic [PTR_W-1:0] ptr, ptr_n, wr_addr_n;
   logic [7:0]       wr_data_n;
   logic             sda_oe, sda_oe_n, ack_ph, ack_ph_n, rw, rw_n;
   logic             busy_n, wr_en_n, addr_hit_n;
   // two-flop synchronizers plus one history stage for edge detection; idle-high reset avoids false events
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         scl_p <= 3'b111;
         sda_p <= 3'b111;
      end else begin
         scl_p <= {scl_p[1:0], scl};
         sda_p <= {sda_p[1:0], sda};
      end
   end
   assign sda_s   = sda_p[1];
   assign rise    = scl_p[1] & ~scl_p[2];
   assign fall    = ~scl_p[1] & scl_p[2];
   assign start   = scl_p[1] & scl_p[2] & ~sda_p[1] & sda_p[2];
   assign stop    = scl_p[1] & scl_p[2] & sda_p[1] & ~sda_p[2];
   assign rd_addr = ptr;
   // reset and a detected START drop the drive immediately instead of waiting for the next edge
   assign sda = (sda_oe && !sys_rst && !start) ? 1'b0 : 1'bz;
   // protocol state and datapath registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         sh       <= '0;
         ptr      <= '0;
         sda_oe   <= 1'b0;
         ack_ph   <= 1'b0;
         rw       <= 1'b0;
         busy     <= 1'b0;
         wr_en    <= 1'b0;
         addr_hit <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         sh       <= sh_n;
         ptr      <= ptr_n;
         sda_oe   <= sda_oe_n;
         ack_ph   <= ack_ph_n;
         rw       <= rw_n;
         busy     <= busy_n;
         wr_en    <= wr_en_n;
         addr_hit <= addr_hit_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
      end
   end
   // next-state: START/STOP override everything, otherwise act on synced SCL edges
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      sh_n       = sh;
      ptr_n      = ptr;
      sda_oe_n   = sda_oe;
      ack_ph_n   = ack_ph;
      rw_n       = rw;
      busy_n     = busy;
      wr_en_n    = 1'b0;
      addr_hit_n = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      bt         = {sh[6:0], sda_s};
      if (start) begin
         state_n   = ADDR;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         ack_ph_n  = 1'b0;
      end else if (stop) begin
         state_n  = IDLE;
         sda_oe_n = 1'b0;
         ack_ph_n = 1'b0;
         busy_n   = 1'b0;
      end else begin
         case (state)
            ADDR, PTR, WDATA: if (rise) begin
               sh_n      = bt;
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (state == ADDR) begin
                     addr_hit_n = (bt[7:1] == SLAVE_ADDR);
                     busy_n     = (bt[7:1] == SLAVE_ADDR);
                     rw_n       = bt[0];
                     state_n    = (bt[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                  end else if (state == PTR) begin
                     ptr_n   = PTR_W'(bt);
                     state_n = PTR_ACK;
                  end else begin
                     wr_en_n   = 1'b1;
                     wr_addr_n = ptr;
                     wr_data_n = bt;
                     ptr_n     = ptr + PTR_W'(1);
                     state_n   = WDATA_ACK;
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (fall) begin
               sda_oe_n = ~ack_ph;
               ack_ph_n = ~ack_ph;
               if (ack_ph) begin
                  state_n = (state == ADDR_ACK) ? (rw ? RDATA : PTR) : WDATA;
                  if (state == ADDR_ACK && rw) begin
                     sh_n      = rd_data;
                     sda_oe_n  = ~rd_data[7];
                     bit_cnt_n = '0;
                  end
               end
            end
            RD_LOAD: if (fall) begin
               sh_n      = rd_data;
               sda_oe_n  = ~rd_data[7];
               bit_cnt_n = '0;
               state_n   = RDATA;
            end
            RDATA: if (fall) begin
               if (bit_cnt == 3'd7) begin
                  sda_oe_n  = 1'b0;
                  bit_cnt_n = '0;
                  state_n   = RD_ACK;
               end else begin
                  sda_oe_n  = ~sh[6];
                  sh_n      = {sh[6:0], 1'b0};
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end
            RD_ACK: if (rise) begin
               ptr_n   = ptr + PTR_W'(1);
               state_n = sda_s ? IDLE : RD_LOAD;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: byte-level bus master with a transaction model of the register target
module tb_i2c_slave_regs;
   localparam int Q = 625;
   logic        sys_clk = 1'b0, sys_rst = 1'b1, scl = 1'b1, sda_m = 1'b0;
   wire         sda;
   logic        wr_en, addr_hit, busy;
   logic [7:0]  wr_addr, wr_data, rd_addr, rd_data;
   logic [7:0]  regs [256];
   logic [15:0] exp_q [$];
   logic [15:0] wlog [$];
   logic [7:0]  mp = 8'h00;
   logic        sel = 1'b0;
   logic        scl_q = 1'b1, sda_q = 1'b1, sda_m_q = 1'b0;
   int          total = 0, bad = 0, exp_hits = 0, hit_cnt = 0, glitch_cnt = 0, slave_low = 0;
   always #10 sys_clk = ~sys_clk;
   assign sda = sda_m ? 1'b0 : 1'bz;
   pullup (sda);
   assign rd_data = regs[rd_addr];
   i2c_slave_regs dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .scl     (scl),
      .sda     (sda),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .addr_hit(addr_hit),
      .busy    (busy)
   );
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // per-cycle compare: every write must match the model queue; watch for SDA moving under high SCL
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (wr_en) begin
            wlog.push_back({wr_addr, wr_data});
            if (exp_q.size() == 0) chk("unexpected_wr", {wr_addr, wr_data}, -1);
            else chk("wr", {wr_addr, wr_data}, exp_q.pop_front());
         end
         if (addr_hit) hit_cnt++;
         if (scl && scl_q && sda !== sda_q && sda_m == sda_m_q) glitch_cnt++;
         if (sda === 1'b0 && !sda_m) slave_low++;
      end
      scl_q   = scl;
      sda_q   = sda;
      sda_m_q = sda_m;
   end
   task automatic wbit(input logic b);
      sda_m = ~b;
      #(Q) scl = 1'b1;
      #(2*Q) scl = 1'b0;
      #(Q);
   endtask
   task automatic rbit(output logic b);
      sda_m = 1'b0;
      #(Q) scl = 1'b1;
      #(Q) b = sda;
      #(Q) scl = 1'b0;
      #(Q);
   endtask
   task automatic i2c_start();
      sda_m = 1'b0;
      #(Q) scl = 1'b1;
      #(Q) sda_m = 1'b1;
      #(Q) scl = 1'b0;
      #(Q);
   endtask
   task automatic i2c_stop();
      sda_m = 1'b1;
      #(Q) scl = 1'b1;
      #(Q) sda_m = 1'b0;
      #(Q);
   endtask
   task automatic wbyte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) wbit(v[i]);
      rbit(b);
      ack = ~b;
   endtask
   task automatic rbyte(input logic nack, output logic [7:0] v);
      logic b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         rbit(b);
         v = {v[6:0], b};
      end
      wbit(nack);
   endtask
   task automatic m_addr(input logic [7:0] ab);
      logic ack;
      i2c_start();
      sel = (ab[7:1] == 7'h73);
      if (sel) exp_hits++;
      wbyte(ab, ack);
      chk("addr_ack", ack, sel);
      if (sel) chk("busy_set", busy, 1);
   endtask
   task automatic m_ptr(input logic [7:0] b);
      logic ack;
      wbyte(b, ack);
      chk("ptr_ack", ack, sel);
      if (sel) mp = b;
   endtask
   task automatic m_wr(input logic [7:0] b);
      logic ack;
      if (sel) exp_q.push_back({mp, b});
      wbyte(b, ack);
      chk("wr_ack", ack, sel);
      if (sel) mp = mp + 8'd1;
   endtask
   task automatic m_rd(input logic nack, output logic [7:0] v);
      rbyte(nack, v);
      chk("rd_byte", v, regs[mp]);
      mp = mp + 8'd1;
   endtask
   task automatic m_stop();
      i2c_stop();
      sel = 1'b0;
      chk("busy_clr", busy, 0);
   endtask
   initial begin
      logic [7:0] v;
      logic [7:0] ab;
      int low0;
      for (int i = 0; i < 256; i++) regs[i] = 8'(i * 7 + 1);
      regs[8'h20] = 8'h3C;
      regs[8'h21] = 8'hC3;
      repeat (5) @(posedge sys_clk);
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_addr_hit", addr_hit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_sda", sda, 1);
      sys_rst = 1'b0;
      #(Q);
      m_addr(8'hE6);
      m_ptr(8'h10);
      m_wr(8'hAA);
      m_wr(8'h55);
      m_stop();
      chk("t1_w0", wlog[0], 16'h10AA);
      chk("t1_w1", wlog[1], 16'h1155);
      m_addr(8'hE6);
      m_ptr(8'h20);
      m_addr(8'hE7);
      m_rd(1'b0, v);
      chk("t2_b0", v, 8'h3C);
      m_rd(1'b1, v);
      chk("t2_b1", v, 8'hC3);
      m_stop();
      chk("t2_rd_addr", rd_addr, 8'h22);
      low0 = slave_low;
      m_addr(8'hE8);
      m_ptr(8'h10);
      m_wr(8'h77);
      m_stop();
      chk("t3_no_drive", slave_low - low0, 0);
      chk("t3_no_wr", wlog.size(), 2);
      chk("t3_ptr_kept", rd_addr, 8'h22);
      m_addr(8'hE6);
      m_ptr(8'hFF);
      m_wr(8'h01);
      m_wr(8'h02);
      m_stop();
      chk("t4_w0", wlog[2], 16'hFF01);
      chk("t4_w1", wlog[3], 16'h0002);
      chk("t4_rd_addr", rd_addr, 8'h01);
      m_addr(8'hE6);
      m_ptr(8'h40);
      wbit(1'b1);
      wbit(1'b0);
      wbit(1'b1);
      wbit(1'b0);
      m_stop();
      chk("t5_abort_no_wr", wlog.size(), 4);
      chk("t5_ptr_only", rd_addr, 8'h40);
      ab = 8'hE6;
      i2c_start();
      exp_hits++;
      for (int i = 7; i >= 0; i--) wbit(ab[i]);
      sda_m = 1'b0;
      #(Q);
      chk("t5_ack_low", sda, 0);
      @(negedge sys_clk) sys_rst = 1'b1;
      @(posedge sys_clk) #1;
      chk("t5_rst_release", sda, 1);
      repeat (3) @(posedge sys_clk);
      sys_rst = 1'b0;
      mp = 8'h00;
      sel = 1'b0;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ptr", rd_addr, 0);
      i2c_stop();
      m_addr(8'hE6);
      m_ptr(8'h50);
      m_wr(8'h99);
      m_stop();
      chk("t5_next_w", wlog[4], 16'h5099);
      #(Q);
      chk("addr_hits", hit_cnt, exp_hits);
      chk("sda_glitch", glitch_cnt, 0);
      chk("writes_pending", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
